// File: rtl/driver_leds_pwm.sv
// Memory-mapped LED controller: NUM_LEDS outputs, each either static or gated
// by a shared PWM dimmer and a frame-counted blink generator.
module driver_leds_pwm #(
    parameter int NUM_LEDS = 10,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chip_select,
    input  logic                write_enable,
    input  logic [2:0]          address,
    input  logic [31:0]         data_write,
    output logic [31:0]         data_read,
    output logic [NUM_LEDS-1:0] ledr
);

    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [2:0] {
        ADDR_VALUE  = 3'd0,
        ADDR_MODE   = 3'd1,
        ADDR_DUTY   = 3'd2,
        ADDR_BLINK  = 3'd3,
        ADDR_SET    = 3'd4,
        ADDR_CLR    = 3'd5,
        ADDR_STATUS = 3'd6,
        ADDR_ID     = 3'd7
    } reg_addr_e;

    logic [NUM_LEDS-1:0] r_value;
    logic [NUM_LEDS-1:0] r_mode;
    logic [PWM_BITS-1:0] r_duty;
    logic [15:0]         r_blink_period;
    logic [PS_W-1:0]     r_ps_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [15:0]         r_blink_cnt;
    logic                r_blink_phase;
    logic [31:0]         r_data_read;
    logic [NUM_LEDS-1:0] r_ledr;

    logic                w_write;
    logic                w_wr_blink;
    logic [NUM_LEDS-1:0] w_wdata_leds;
    logic                w_tick;
    logic                w_frame_end;
    logic                w_pwm_on;
    logic                w_blink_wrap;
    logic [NUM_LEDS-1:0] w_led_next;
    logic [31:0]         w_rd_data;
    logic                w_unused;

    assign w_write      = chip_select & write_enable;
    assign w_wr_blink   = w_write && (reg_addr_e'(address) == ADDR_BLINK);
    assign w_wdata_leds = data_write[NUM_LEDS-1:0];
    // Write-data bits above the register widths are discarded on purpose.
    assign w_unused     = ^data_write;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value        <= '0;
            r_mode         <= '0;
            r_duty         <= '0;
            r_blink_period <= '0;
        end else if (w_write) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            case (reg_addr_e'(address))
                ADDR_VALUE: r_value        <= w_wdata_leds;
                ADDR_MODE:  r_mode         <= w_wdata_leds;
                ADDR_DUTY:  r_duty         <= data_write[PWM_BITS-1:0];
                ADDR_BLINK: r_blink_period <= data_write[15:0];
                ADDR_SET:   r_value        <= r_value | w_wdata_leds;
                ADDR_CLR:   r_value        <= r_value & ~w_wdata_leds;
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and PWM frame counter
    // ------------------------------------------------------------------
    assign w_tick      = (r_ps_cnt == PS_MAX);
    assign w_frame_end = w_tick & (&r_pwm_cnt);
    assign w_pwm_on    = (r_pwm_cnt < r_duty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ps_cnt <= '0;
        end else if (w_tick) begin
            r_ps_cnt <= '0;
        end else begin
            r_ps_cnt <= r_ps_cnt + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // ------------------------------------------------------------------
    // Blink generator: phase toggles every BLINK frames
    // ------------------------------------------------------------------
    assign w_blink_wrap = (r_blink_cnt == r_blink_period - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_wr_blink || (r_blink_period == 16'd0)) begin
            // A new period restarts the blink cycle in the lit phase.
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end) begin
            if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves w_rd_data unassigned (no latch).
        w_rd_data = '0;
        case (reg_addr_e'(address))
            ADDR_VALUE:  w_rd_data = 32'(r_value);
            ADDR_MODE:   w_rd_data = 32'(r_mode);
            ADDR_DUTY:   w_rd_data = 32'(r_duty);
            ADDR_BLINK:  w_rd_data = 32'(r_blink_period);
            ADDR_STATUS: w_rd_data = {15'd0, r_blink_phase, 16'(r_pwm_cnt)};
            ADDR_ID:     w_rd_data = 32'(NUM_LEDS);
            default:     w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_read <= '0;
        end else if (chip_select) begin
            r_data_read <= w_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // LED output stage
    // ------------------------------------------------------------------
    assign w_led_next = r_value & (~r_mode | {NUM_LEDS{w_pwm_on & r_blink_phase}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ledr <= '0;
        end else begin
            r_ledr <= w_led_next;
        end
    end

    assign data_read = r_data_read;
    assign ledr      = r_ledr;

endmodule
